// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
// The arbiter connects through the slave modport; masters and the RAM drive the master side.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_rdata,
    output m0_ack, m0_rvalid, m0_rdata,
    output m1_ack, m1_rvalid, m1_rdata,
    output ram_addr, ram_we, ram_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_rdata,
    input  m0_ack, m0_rvalid, m0_rdata,
    input  m1_ack, m1_rvalid, m1_rdata,
    input  ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the core (m0)
// and the load/debug port (m1); single-word transfers, all outputs registered.
module ram_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_port_arbiter_if.slave    bus,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_READ_WAIT,
    S_READ_DONE
  } state_t;

  state_t              state_q;
  logic                last_winner_q;
  logic                win_q;
  logic                we_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                m0_ack_q;
  logic                m1_ack_q;
  logic                m0_rvalid_q;
  logic                m1_rvalid_q;
  logic [DATA_W-1:0]   m0_rdata_q;
  logic [DATA_W-1:0]   m1_rdata_q;

  logic                req_any_d;
  logic                grant_id_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;

  // m1 wins when it is alone, or on a tie when m0 was served last.
  always_comb begin
    req_any_d   = bus.m0_req | bus.m1_req;
    grant_id_d  = bus.m1_req & (~bus.m0_req | ~last_winner_q);
    sel_we_d    = bus.m0_we;
    sel_addr_d  = bus.m0_addr;
    sel_wdata_d = bus.m0_wdata;
    if (grant_id_d) begin
      sel_we_d    = bus.m1_we;
      sel_addr_d  = bus.m1_addr;
      sel_wdata_d = bus.m1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_winner_q <= 1'b1;
      win_q         <= 1'b0;
      we_q          <= 1'b0;
      ram_we_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_rvalid_q   <= 1'b0;
      m1_rvalid_q   <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      ram_we_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req_any_d) begin
            win_q         <= grant_id_d;
            last_winner_q <= grant_id_d;
            we_q          <= sel_we_d;
            addr_q        <= sel_addr_d;
            wdata_q       <= sel_wdata_d;
            ram_we_q      <= sel_we_d;
            m0_ack_q      <= ~grant_id_d;
            m1_ack_q      <= grant_id_d;
            state_q       <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          state_q <= we_q ? S_IDLE : S_READ_WAIT;
        end
        // RAM output now reflects the address presented during ACCESS.
        S_READ_WAIT: begin
          if (win_q) begin
            m1_rdata_q  <= bus.ram_rdata;
            m1_rvalid_q <= 1'b1;
          end else begin
            m0_rdata_q  <= bus.ram_rdata;
            m0_rvalid_q <= 1'b1;
          end
          state_q <= S_READ_DONE;
        end
        S_READ_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign bus.ram_addr  = addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares the single-port synchronous data/program RAM of the K-and-S core between the processor (master 0) and the program-load/debug port (master 1). Each master issues single-word read or write requests over a req/ack handshake. The arbiter serializes them onto the RAM port with round-robin fairness and returns read data with a one-cycle valid strobe. It sits between the core's memory interface and the RAM macro.

## Interface
- ADDR_W, 5, RAM word-address width
- DATA_W, 16, RAM data width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m0_req, m1_req  in  1  access request; held with fields stable until own ack
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_W  word address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_ack, m1_ack  out  1  one-cycle pulse: request accepted and issued to RAM
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse: read data valid
- m0_rdata, m1_rdata  out  DATA_W  read data; holds until that master's next read completes
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after the address is presented
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, READ_WAIT, READ_DONE.
- IDLE:
  - No req: stay.
  - Exactly one req: that master wins.
  - Both req: winner is the master that did not win last (last_winner register).
  - On a win: latch winner id, we, addr and wdata into internal registers; update last_winner; go to ACCESS.
- ACCESS, one cycle:
  - ram_addr = latched addr; ram_we = latched we; ram_wdata = latched wdata.
  - ack of the winner = 1.
  - Write: next state IDLE. Read: next state READ_WAIT.
- READ_WAIT, one cycle:
  - ram_addr held, ram_we = 0.
  - Winner's rdata register <= ram_rdata.
  - Next state READ_DONE.
- READ_DONE, one cycle:
  - Winner's rvalid = 1.
  - Next state IDLE.
- All req inputs are ignored outside IDLE; a losing request stays pending and is served next.
- A master must deassert req, or present a new request, in the cycle after its ack. A req still high in IDLE is treated as a new request.
- Outputs m*_ack, m*_rvalid, ram_we, ram_addr and ram_wdata are registered (driven from state/latched registers, no combinational path from req).
- The other master's ack and rvalid are never asserted during a transfer. Its rdata is unchanged.

## Timing
- Request sampled at edge E0 (IDLE). ACCESS occupies cycle E0→E1; ack and ram_we are visible in that cycle.
- Write: 2 cycles from sampling to next IDLE; back-to-back writes by one master every 2 cycles.
- Read: rvalid high in the 3rd cycle after the sampling edge; 4-cycle turnaround per read.
- ram_we is high for exactly one cycle per write and never during reads.
- Reset (asserted at any time, including mid-ACCESS or READ_WAIT):
  - state = IDLE; last_winner = m1, so m0 wins the first tie.
  - All outputs = 0, including rdata registers, ram_addr and ram_wdata.
  - An in-flight transfer is discarded: no ack and no rvalid after reset.
  - A write in its ACCESS cycle when reset asserts is not guaranteed to reach the RAM.
- Fairness: with both masters requesting continuously, grants strictly alternate; no master waits more than one transfer.

## Test plan
- Reset then single write: m0 write addr 5, data 0xBEEF → ACCESS cycle with ram_we=1, ram_addr=5, ram_wdata=0xBEEF; m0_ack one pulse; busy falls after 2 cycles.
- Read back: m0 read addr 5, RAM model returns 0xBEEF → m0_ack, then m0_rvalid 2 cycles later with m0_rdata=0xBEEF; m1_rvalid stays 0.
- Simultaneous requests after reset: m0 write addr 1 = 0x0001, m1 write addr 2 = 0x0002 → m0 served first, then m1. Repeat both continuously for 6 transfers → grants alternate m1, m0, m1, …
- Mixed contention: m0 read addr 2 and m1 write addr 3 = 0x1234 raised together, last winner m0 → m1 write first, m0 read next, m0_rdata=0x0002. Req held during a busy transfer receives no early ack.
- Reset mid-operation: assert rst during READ_WAIT of an m1 read → all outputs 0 immediately; no m1_rvalid after release; first tie after release goes to m0.
- Wrap/edges: write addr 31 = 0xFFFF, then read addr 0 and addr 31 → correct values; m1_rdata holds 0xFFFF across a subsequent m0 transfer.
